// File: rtl/alu_arbiter.sv
// Two-port arbiter for the shared execute-stage ALU with registered per-port response slots.
// Define ALU_ARB_RR_EN for round-robin contention; default build is fixed priority (port 0 wins).
module alu_arbiter #(
    parameter int ALU_BITS      = 32,
    parameter int ALU_CTRL_BITS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [ALU_BITS-1:0]      req0_in1,
    input  logic [ALU_BITS-1:0]      req0_in2,
    input  logic [ALU_CTRL_BITS-1:0] req0_ctrl,

    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [ALU_BITS-1:0]      req1_in1,
    input  logic [ALU_BITS-1:0]      req1_in2,
    input  logic [ALU_CTRL_BITS-1:0] req1_ctrl,

    output logic                     rsp0_valid,
    input  logic                     rsp0_ready,
    output logic [ALU_BITS-1:0]      rsp0_result,
    output logic                     rsp0_is_zero,

    output logic                     rsp1_valid,
    input  logic                     rsp1_ready,
    output logic [ALU_BITS-1:0]      rsp1_result,
    output logic                     rsp1_is_zero,

    output logic [ALU_BITS-1:0]      alu_in1,
    output logic [ALU_BITS-1:0]      alu_in2,
    output logic [ALU_CTRL_BITS-1:0] alu_ctrl,
    input  logic [ALU_BITS-1:0]      alu_result,
    input  logic                     alu_is_zero,

    output logic [15:0]              conflict_cnt
);

    logic [1:0]          req_valid;
    logic [1:0]          rsp_ready;
    logic [1:0]          free;
    logic [1:0]          elig;
    logic [1:0]          grant;
    logic                both;
    logic                prefer1;

    logic [1:0]          valid_q;
    logic [1:0]          valid_d;
    logic [ALU_BITS-1:0] res_q [2];
    logic [ALU_BITS-1:0] res_d [2];
    logic [1:0]          zero_q;
    logic [1:0]          zero_d;
    logic [15:0]         cnt_q;
    logic [15:0]         cnt_d;

    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};

    // A slot that drains this cycle can take a new result on the same edge.
    assign free = ~valid_q | rsp_ready;
    assign elig = req_valid & free;
    assign both = &elig;

    always_comb begin
        grant = 2'b00;
        case (elig)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prefer1 ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

`ifdef ALU_ARB_RR_EN
    logic ptr_q;
    logic ptr_d;

    assign ptr_d   = (grant != 2'b00) ? grant[0] : ptr_q;
    assign prefer1 = ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign prefer1 = 1'b0;
`endif

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    always_comb begin
        alu_in1  = '0;
        alu_in2  = '0;
        alu_ctrl = '0;
        if (grant[0]) begin
            alu_in1  = req0_in1;
            alu_in2  = req0_in2;
            alu_ctrl = req0_ctrl;
        end else if (grant[1]) begin
            alu_in1  = req1_in1;
            alu_in2  = req1_in2;
            alu_ctrl = req1_ctrl;
        end
    end

    always_comb begin
        valid_d = valid_q;
        zero_d  = zero_q;
        res_d   = res_q;
        for (int n = 0; n < 2; n++) begin
            if (grant[n]) begin
                valid_d[n] = 1'b1;
                res_d[n]   = alu_result;
                zero_d[n]  = alu_is_zero;
            end else if (valid_q[n] && rsp_ready[n]) begin
                valid_d[n] = 1'b0;
            end
        end
    end

    assign cnt_d = (both && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            zero_q  <= '0;
            cnt_q   <= '0;
            for (int n = 0; n < 2; n++) begin
                res_q[n] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            zero_q  <= zero_d;
            cnt_q   <= cnt_d;
            for (int n = 0; n < 2; n++) begin
                res_q[n] <= res_d[n];
            end
        end
    end

    assign rsp0_valid   = valid_q[0];
    assign rsp1_valid   = valid_q[1];
    assign rsp0_result  = res_q[0];
    assign rsp1_result  = res_q[1];
    assign rsp0_is_zero = zero_q[0];
    assign rsp1_is_zero = zero_q[1];
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, directed corner sequences
// and randomized traffic against a transaction-level reference model.
module tb_alu_arbiter;

    localparam int W = 32;
    localparam int C = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         r_valid [2];
    logic [W-1:0] r_in1 [2];
    logic [W-1:0] r_in2 [2];
    logic [C-1:0] r_ctrl [2];
    logic         s_ready [2];

    logic         req0_ready, req1_ready;
    logic         rsp0_valid, rsp1_valid;
    logic [W-1:0] rsp0_result, rsp1_result;
    logic         rsp0_is_zero, rsp1_is_zero;
    logic [W-1:0] alu_in1, alu_in2, alu_result;
    logic [C-1:0] alu_ctrl;
    logic         alu_is_zero;
    logic [15:0]  conflict_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b1;

    // reference model state
    bit           m_v [2];
    logic [W-1:0] m_res [2];
    bit           m_z [2];
    int           m_cnt;
    int           m_ptr;
    bit           m_g [2];
    logic         dut_rdy [2];

    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu_f(input logic [C-1:0] c,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        case (c)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            default: return '0;
        endcase
    endfunction

    assign alu_result  = alu_f(alu_ctrl, alu_in1, alu_in2);
    assign alu_is_zero = (alu_result == '0);

    alu_arbiter #(.ALU_BITS(W), .ALU_CTRL_BITS(C)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r_valid[0]), .req0_ready(req0_ready),
        .req0_in1(r_in1[0]), .req0_in2(r_in2[0]), .req0_ctrl(r_ctrl[0]),
        .req1_valid(r_valid[1]), .req1_ready(req1_ready),
        .req1_in1(r_in1[1]), .req1_in2(r_in2[1]), .req1_ctrl(r_ctrl[1]),
        .rsp0_valid(rsp0_valid), .rsp0_ready(s_ready[0]),
        .rsp0_result(rsp0_result), .rsp0_is_zero(rsp0_is_zero),
        .rsp1_valid(rsp1_valid), .rsp1_ready(s_ready[1]),
        .rsp1_result(rsp1_result), .rsp1_is_zero(rsp1_is_zero),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_is_zero(alu_is_zero),
        .conflict_cnt(conflict_cnt)
    );

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            m_v[n] = 0; m_res[n] = '0; m_z[n] = 0; m_g[n] = 0;
        end
        m_cnt = 0;
        m_ptr = 0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, " rsp0_valid"}, W'(rsp0_valid), W'(m_v[0]));
        chk({tag, " rsp1_valid"}, W'(rsp1_valid), W'(m_v[1]));
        chk({tag, " rsp0_result"}, rsp0_result, m_res[0]);
        chk({tag, " rsp1_result"}, rsp1_result, m_res[1]);
        chk({tag, " rsp0_is_zero"}, W'(rsp0_is_zero), W'(m_z[0]));
        chk({tag, " rsp1_is_zero"}, W'(rsp1_is_zero), W'(m_z[1]));
        chk({tag, " conflict_cnt"}, W'(conflict_cnt), W'(m_cnt));
    endtask

    // One clock: check at negedge, advance model at posedge, return at posedge+1.
    task automatic step();
        bit           el [2];
        bit           g [2];
        logic [W-1:0] e1, e2;
        logic [C-1:0] ec;
        @(negedge clk);
        for (int n = 0; n < 2; n++) begin
            el[n] = r_valid[n] && (!m_v[n] || s_ready[n]);
            g[n]  = el[n];
        end
        if (el[0] && el[1]) begin
`ifdef ALU_ARB_RR_EN
            g[0] = (m_ptr == 0);
            g[1] = (m_ptr == 1);
`else
            g[0] = 1;
            g[1] = 0;
`endif
        end
        e1 = '0; e2 = '0; ec = '0;
        for (int n = 1; n >= 0; n--) begin
            if (g[n]) begin
                e1 = r_in1[n]; e2 = r_in2[n]; ec = r_ctrl[n];
            end
        end
        dut_rdy[0] = req0_ready;
        dut_rdy[1] = req1_ready;
        if (chk_en) begin
            chk("req0_ready", W'(req0_ready), W'(g[0]));
            chk("req1_ready", W'(req1_ready), W'(g[1]));
            chk("alu_in1", alu_in1, e1);
            chk("alu_in2", alu_in2, e2);
            chk("alu_ctrl", W'(alu_ctrl), W'(ec));
            check_regs("cyc");
        end
        @(posedge clk);
        for (int n = 0; n < 2; n++) begin
            if (g[n]) begin
                m_v[n]   = 1;
                m_res[n] = alu_f(r_ctrl[n], r_in1[n], r_in2[n]);
                m_z[n]   = (m_res[n] == '0);
            end else if (m_v[n] && s_ready[n]) begin
                m_v[n] = 0;
            end
            m_g[n] = g[n];
        end
        if (el[0] && el[1] && m_cnt < 65535) m_cnt++;
        if (g[0]) m_ptr = 1;
        else if (g[1]) m_ptr = 0;
        #1;
    endtask

    task automatic idle_inputs();
        for (int n = 0; n < 2; n++) begin
            r_valid[n] = 0; r_in1[n] = '0; r_in2[n] = '0;
            r_ctrl[n] = '0; s_ready[n] = 1;
        end
    endtask

    // Asynchronous assert mid-cycle, release away from the rising edge.
    task automatic hit_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_regs("reset");
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit           port;
        logic [C-1:0] ctrl;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        bit           z;
    } vec_t;

    vec_t vt [7];

    initial begin
        vt[0] = '{1'b1, 4'd0, 32'd5, 32'd7, 32'd12, 1'b0};
        vt[1] = '{1'b1, 4'd1, 32'd9, 32'd9, 32'd0, 1'b1};
        vt[2] = '{1'b0, 4'd2, 32'hF0, 32'h3C, 32'h30, 1'b0};
        vt[3] = '{1'b0, 4'd3, 32'hF0, 32'h0F, 32'hFF, 1'b0};
        vt[4] = '{1'b1, 4'd4, 32'hA5A5, 32'hA5A5, 32'h0, 1'b1};
        vt[5] = '{1'b0, 4'd0, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b1};
        vt[6] = '{1'b1, 4'd1, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0};

        idle_inputs();
        model_reset();
        #1;
        check_regs("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // reset mid-traffic with rsp0 full
        r_valid[0] = 1; r_ctrl[0] = 4'd0; r_in1[0] = 32'd3; r_in2[0] = 32'd4;
        s_ready[0] = 0;
        step();
        chk("pre-reset rsp0_valid", W'(rsp0_valid), W'(1'b1));
        hit_reset();

        // vector table, one op from idle each
        for (int i = 0; i < 7; i++) begin
            r_valid[vt[i].port] = 1;
            r_ctrl[vt[i].port]  = vt[i].ctrl;
            r_in1[vt[i].port]   = vt[i].a;
            r_in2[vt[i].port]   = vt[i].b;
            step();
            r_valid[vt[i].port] = 0;
            chk($sformatf("vec%0d result", i),
                vt[i].port ? rsp1_result : rsp0_result, vt[i].res);
            chk($sformatf("vec%0d is_zero", i),
                W'(vt[i].port ? rsp1_is_zero : rsp0_is_zero), W'(vt[i].z));
            step();
        end

        // idle drives zero onto the ALU
        idle_inputs();
        step();
        chk("idle alu_ctrl", W'(alu_ctrl), '0);
        chk("idle alu_in1", alu_in1, '0);
        chk("idle alu_in2", alu_in2, '0);

        // single-port streaming
        s_ready[0] = 1;
        for (int i = 1; i <= 4; i++) begin
            r_valid[0] = 1; r_ctrl[0] = 4'd0;
            r_in1[0] = W'(i); r_in2[0] = W'(i);
            step();
            chk("stream req0_ready", W'(dut_rdy[0]), W'(1'b1));
            chk("stream rsp0_result", rsp0_result, W'(2 * i));
        end
        idle_inputs();
        step();

        // contention
        hit_reset();
        r_valid[0] = 1; r_ctrl[0] = 4'd0; r_in1[0] = 32'd1; r_in2[0] = 32'd2;
        r_valid[1] = 1; r_ctrl[1] = 4'd0; r_in1[1] = 32'd10; r_in2[1] = 32'd20;
        for (int i = 0; i < 6; i++) begin
            step();
`ifdef ALU_ARB_RR_EN
            chk("rr req0_ready", W'(dut_rdy[0]), W'(i % 2 == 0));
            chk("rr req1_ready", W'(dut_rdy[1]), W'(i % 2 == 1));
`else
            chk("fixed req0_ready", W'(dut_rdy[0]), W'(1'b1));
            chk("fixed req1_ready", W'(dut_rdy[1]), W'(1'b0));
`endif
        end
        chk("contention conflict_cnt", W'(conflict_cnt), W'(6));
        idle_inputs();
        step();

        // backpressure on port 0
        r_valid[0] = 1; r_ctrl[0] = 4'd0; r_in1[0] = 32'h8; r_in2[0] = 32'h8;
        step();
        chk("bp first rsp0_result", rsp0_result, 32'h10);
        s_ready[0] = 0;
        r_in1[0] = 32'd1; r_in2[0] = 32'd1;
        for (int i = 0; i < 4; i++) begin
            r_valid[1] = 1; r_ctrl[1] = 4'd3;
            r_in1[1] = W'(i); r_in2[1] = W'(16 * i);
            step();
            chk("bp req0_ready", W'(dut_rdy[0]), W'(1'b0));
            chk("bp req1_ready", W'(dut_rdy[1]), W'(1'b1));
            chk("bp rsp0_result hold", rsp0_result, 32'h10);
        end
        r_valid[1] = 0;
        s_ready[0] = 1;
        step();
        chk("bp drain+accept ready", W'(dut_rdy[0]), W'(1'b1));
        chk("bp drain+accept valid", W'(rsp0_valid), W'(1'b1));
        chk("bp drain+accept result", rsp0_result, 32'd2);
        idle_inputs();
        step();

        // randomized traffic; stalled requesters hold their payload
        for (int c = 0; c < 400; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (!(r_valid[n] && !m_g[n])) begin
                    r_valid[n] = ($urandom_range(0, 3) != 0);
                    r_ctrl[n]  = C'($urandom_range(0, 4));
                    r_in1[n]   = $urandom;
                    r_in2[n]   = ($urandom_range(0, 3) == 0) ? r_in1[n] : $urandom;
                end
                s_ready[n] = ($urandom_range(0, 3) != 0);
            end
            step();
        end

        // counter saturation
        hit_reset();
        r_valid[0] = 1; r_valid[1] = 1;
        chk_en = 1'b0;
        for (int c = 0; c < 65540; c++) step();
        chk_en = 1'b1;
        chk("sat conflict_cnt", W'(conflict_cnt), 32'hFFFF);
        step();
        chk("sat no wrap", W'(conflict_cnt), 32'hFFFF);
        idle_inputs();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
